alu_result_wb: RTL and testbench

//  Consumer end of the ALU result interface: accepts one ALU result per handshake,

---
 rtl/alu_result_wb.sv | 148 ++++++++++++++
 tb/tb_alu_result_wb.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_wb.sv
// Consumer end of the ALU result interface: commits MUL/DIV results to HI/LO,
// captures status flags and drives the register-file write port with back-pressure.
module alu_result_wb #(
    parameter int          DW      = 32,
    parameter logic [5:0]  FS_MUL  = 6'h1E,
    parameter logic [5:0]  FS_DIV  = 6'h1F,
    parameter logic [5:0]  FS_MFHI = 6'h3C,
    parameter logic [5:0]  FS_MFLO = 6'h3D
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [5:0]    FS,
    input  logic [4:0]    D_addr,
    input  logic [DW-1:0] Y_hi,
    input  logic [DW-1:0] Y_lo,
    input  logic          C,
    input  logic          V,
    input  logic          N,
    input  logic          Z,
    output logic          wr_en,
    output logic [4:0]    wr_addr,
    output logic [DW-1:0] wr_data,
    input  logic          wr_ready,
    output logic [DW-1:0] HI,
    output logic [DW-1:0] LO,
    output logic          C_q,
    output logic          V_q,
    output logic          N_q,
    output logic          Z_q,
    output logic          busy,
    output logic          state_dbg
);

    // Handshake: an op is taken on a rising edge where alu_valid && alu_ready;
    // a write is taken by the register file on a rising edge where wr_en && wr_ready.
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic accept;
    logic is_muldiv;
    logic is_mfhi;
    logic is_mflo;
    logic is_move;
    logic do_write;
    logic [DW-1:0] write_value;

    assign is_muldiv = (FS == FS_MUL) || (FS == FS_DIV);
    assign is_mfhi   = (FS == FS_MFHI);
    assign is_mflo   = (FS == FS_MFLO);
    assign is_move   = is_mfhi || is_mflo;
    assign accept    = alu_valid && alu_ready;
    // Register $0 is hard-wired, so writes aimed at it are dropped entirely.
    assign do_write  = accept && !is_muldiv && (D_addr != 5'd0);

    always_comb begin
        write_value = Y_lo;
        if (is_mfhi) begin
            write_value = HI;
        end else if (is_mflo) begin
            write_value = LO;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (do_write) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (wr_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs depend on state only, so reset drops wr_en without waiting for a clock.
    always_comb begin
        alu_ready = 1'b0;
        wr_en     = 1'b0;
        busy      = 1'b0;
        state_dbg = state_q;
        case (state_q)
            S_IDLE:  alu_ready = 1'b1;
            S_WRITE: begin
                wr_en = 1'b1;
                busy  = 1'b1;
            end
            default: alu_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            HI  <= '0;
            LO  <= '0;
            C_q <= 1'b0;
            V_q <= 1'b0;
            N_q <= 1'b0;
            Z_q <= 1'b0;
        end else if (accept) begin
            if (is_muldiv) begin
                HI  <= Y_hi;
                LO  <= Y_lo;
                C_q <= 1'b0;
                V_q <= 1'b0;
                N_q <= N;
                Z_q <= Z;
            end else if (!is_move) begin
                C_q <= C;
                V_q <= V;
                N_q <= N;
                Z_q <= Z;
            end
        end
    end

    // Address/data are only loaded on accept, so they stay stable throughout a stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_addr <= '0;
            wr_data <= '0;
        end else if (do_write) begin
            wr_addr <= D_addr;
            wr_data <= write_value;
        end
    end

endmodule

// File: tb/tb_alu_result_wb.sv
// Self-checking bench for alu_result_wb: directed scenarios plus randomized ops
// checked against a behavioural HI/LO/flags/write model.
module tb_alu_result_wb;
    localparam int DW = 32;
    localparam logic [5:0] FS_MUL  = 6'h1E;
    localparam logic [5:0] FS_DIV  = 6'h1F;
    localparam logic [5:0] FS_MFHI = 6'h3C;
    localparam logic [5:0] FS_MFLO = 6'h3D;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          alu_valid = 1'b0;
    logic          alu_ready;
    logic [5:0]    FS = '0;
    logic [4:0]    D_addr = '0;
    logic [DW-1:0] Y_hi = '0;
    logic [DW-1:0] Y_lo = '0;
    logic          C = 1'b0, V = 1'b0, N = 1'b0, Z = 1'b0;
    logic          wr_en;
    logic [4:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready = 1'b0;
    logic [DW-1:0] HI, LO;
    logic          C_q, V_q, N_q, Z_q;
    logic          busy;
    logic          state_dbg;

    int total = 0;
    int bad = 0;

    // Reference model: architectural HI/LO, flags, and expected writes {addr,data}.
    logic [DW-1:0] m_hi = '0;
    logic [DW-1:0] m_lo = '0;
    logic [3:0]    m_flags = '0;
    logic [DW+4:0] exp_q[$];

    alu_result_wb dut (
        .clk(clk), .reset(reset), .alu_valid(alu_valid), .alu_ready(alu_ready),
        .FS(FS), .D_addr(D_addr), .Y_hi(Y_hi), .Y_lo(Y_lo),
        .C(C), .V(V), .N(N), .Z(Z),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .HI(HI), .LO(LO), .C_q(C_q), .V_q(V_q), .N_q(N_q), .Z_q(Z_q),
        .busy(busy), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic present(input logic [5:0] fs, input logic [4:0] d,
                           input logic [DW-1:0] yh, input logic [DW-1:0] yl,
                           input logic [3:0] cvnz);
        @(negedge clk);
        FS = fs; D_addr = d; Y_hi = yh; Y_lo = yl;
        {C, V, N, Z} = cvnz;
        alu_valid = 1'b1;
    endtask

    task automatic model_op(input logic [5:0] fs, input logic [4:0] d,
                            input logic [DW-1:0] yh, input logic [DW-1:0] yl,
                            input logic [3:0] cvnz);
        if (fs == FS_MUL || fs == FS_DIV) begin
            m_hi = yh;
            m_lo = yl;
            m_flags = {2'b00, cvnz[1:0]};
        end else if (fs == FS_MFHI || fs == FS_MFLO) begin
            if (d != 0) exp_q.push_back({d, (fs == FS_MFHI) ? m_hi : m_lo});
        end else begin
            m_flags = cvnz;
            if (d != 0) exp_q.push_back({d, yl});
        end
    endtask

    task automatic model_reset();
        m_hi = '0;
        m_lo = '0;
        m_flags = '0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en got=%b exp=0", wr_en); end
        total++; if (HI !== '0 || LO !== '0) begin bad++; $display("FAIL rst_hilo got=%h/%h exp=0/0", HI, LO); end
        total++; if ({C_q, V_q, N_q, Z_q} !== 4'b0) begin bad++; $display("FAIL rst_flags got=%b exp=0000", {C_q, V_q, N_q, Z_q}); end
        total++; if (wr_addr !== 5'd0 || wr_data !== '0 || busy !== 1'b0) begin bad++; $display("FAIL rst_wrport got=%h/%h/%b exp=0/0/0", wr_addr, wr_data, busy); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", alu_ready); end
    endtask

    task automatic test_mul();
        present(FS_MUL, 5'd4, 32'h1, 32'hFFFF_FFFE, 4'b1110);
        model_op(FS_MUL, 5'd4, 32'h1, 32'hFFFF_FFFE, 4'b1110);
        @(posedge clk); #1;
        alu_valid = 1'b0;
        total++; if (HI !== m_hi || LO !== m_lo) begin bad++; $display("FAIL mul_hilo got=%h/%h exp=%h/%h", HI, LO, m_hi, m_lo); end
        total++; if ({C_q, V_q, N_q, Z_q} !== m_flags) begin bad++; $display("FAIL mul_flags got=%b exp=%b", {C_q, V_q, N_q, Z_q}, m_flags); end
        total++; if (wr_en !== 1'b0 || alu_ready !== 1'b1) begin bad++; $display("FAIL mul_nowrite got=%b/%b exp=0/1", wr_en, alu_ready); end
        @(posedge clk); #1;
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL mul_nowrite2 got=%b exp=0", wr_en); end
    endtask

    task automatic test_add_stall();
        present(6'h20, 5'd5, 32'h0, 32'h1234, 4'b0000);
        model_op(6'h20, 5'd5, 32'h0, 32'h1234, 4'b0000);
        wr_ready = 1'b0;
        @(posedge clk); #1;
        alu_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++; if (wr_en !== 1'b1 || alu_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL stall_ctl[%0d] got=%b%b%b exp=101", i, wr_en, alu_ready, busy); end
            total++; if (wr_addr !== 5'd5 || wr_data !== 32'h1234) begin bad++; $display("FAIL stall_port[%0d] got=%h/%h exp=05/00001234", i, wr_addr, wr_data); end
            if (i < 3) begin @(posedge clk); #1; end
        end
        void'(exp_q.pop_front());
        wr_ready = 1'b1;
        @(posedge clk); #1;
        wr_ready = 1'b0;
        total++; if (wr_en !== 1'b0 || alu_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL stall_retire got=%b%b%b exp=010", wr_en, alu_ready, busy); end
    endtask

    task automatic test_back_to_back();
        present(FS_DIV, 5'd0, 32'd3, 32'd7, 4'b0000);
        model_op(FS_DIV, 5'd0, 32'd3, 32'd7, 4'b0000);
        @(posedge clk); #1;
        present(FS_MFHI, 5'd9, 32'hDEAD_0000, 32'hBEEF_0000, 4'b1111);
        model_op(FS_MFHI, 5'd9, 32'hDEAD_0000, 32'hBEEF_0000, 4'b1111);
        wr_ready = 1'b0;
        @(posedge clk); #1;
        alu_valid = 1'b0;
        total++; if (wr_en !== 1'b1 || wr_data !== 32'd3 || wr_addr !== 5'd9) begin bad++; $display("FAIL b2b_mfhi got=%b/%h/%h exp=1/00000003/09", wr_en, wr_data, wr_addr); end
        total++; if ({C_q, V_q, N_q, Z_q} !== m_flags) begin bad++; $display("FAIL b2b_flags got=%b exp=%b", {C_q, V_q, N_q, Z_q}, m_flags); end
        void'(exp_q.pop_front());
        wr_ready = 1'b1;
        @(posedge clk); #1;
        wr_ready = 1'b0;
        present(FS_MFLO, 5'd10, 32'h0, 32'h0, 4'b0000);
        model_op(FS_MFLO, 5'd10, 32'h0, 32'h0, 4'b0000);
        @(posedge clk); #1;
        alu_valid = 1'b0;
        total++; if (wr_data !== 32'd7 || wr_addr !== 5'd10) begin bad++; $display("FAIL b2b_mflo got=%h/%h exp=00000007/0a", wr_data, wr_addr); end
        void'(exp_q.pop_front());
        wr_ready = 1'b1;
        @(posedge clk); #1;
        wr_ready = 1'b0;
    endtask

    task automatic test_zero_target();
        present(6'h20, 5'd0, 32'h0, 32'h55, 4'b0001);
        model_op(6'h20, 5'd0, 32'h0, 32'h55, 4'b0001);
        @(posedge clk); #1;
        alu_valid = 1'b0;
        total++; if (wr_en !== 1'b0 || alu_ready !== 1'b1) begin bad++; $display("FAIL zero_nowrite got=%b/%b exp=0/1", wr_en, alu_ready); end
        total++; if ({C_q, V_q, N_q, Z_q} !== 4'b0001) begin bad++; $display("FAIL zero_flags got=%b exp=0001", {C_q, V_q, N_q, Z_q}); end
        @(posedge clk); #1;
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL zero_nowrite2 got=%b exp=0", wr_en); end
    endtask

    task automatic test_busy_drop();
        present(6'h21, 5'd7, 32'h0, 32'hABCD, 4'b1010);
        model_op(6'h21, 5'd7, 32'h0, 32'hABCD, 4'b1010);
        wr_ready = 1'b0;
        @(posedge clk); #1;
        present(FS_MUL, 5'd3, 32'hDEAD_BEEF, 32'hCAFE_F00D, 4'b0111);
        repeat (3) @(posedge clk);
        #1;
        total++; if (HI !== m_hi || LO !== m_lo) begin bad++; $display("FAIL drop_hilo got=%h/%h exp=%h/%h", HI, LO, m_hi, m_lo); end
        total++; if ({C_q, V_q, N_q, Z_q} !== m_flags) begin bad++; $display("FAIL drop_flags got=%b exp=%b", {C_q, V_q, N_q, Z_q}, m_flags); end
        total++; if (wr_data !== 32'hABCD || wr_addr !== 5'd7 || wr_en !== 1'b1) begin bad++; $display("FAIL drop_port got=%h/%h/%b exp=0000abcd/07/1", wr_data, wr_addr, wr_en); end
        void'(exp_q.pop_front());
        wr_ready = 1'b1;
        @(posedge clk); #1;
        wr_ready = 1'b0;
        total++; if (HI !== m_hi || wr_en !== 1'b0) begin bad++; $display("FAIL drop_retire got=%h/%b exp=%h/0", HI, wr_en, m_hi); end
        model_op(FS_MUL, 5'd3, 32'hDEAD_BEEF, 32'hCAFE_F00D, 4'b0111);
        @(posedge clk); #1;
        alu_valid = 1'b0;
        total++; if (HI !== m_hi || LO !== m_lo) begin bad++; $display("FAIL drop_held_mul got=%h/%h exp=%h/%h", HI, LO, m_hi, m_lo); end
    endtask

    task automatic test_mid_write_reset();
        present(FS_MUL, 5'd0, 32'hAA, 32'hBB, 4'b0000);
        model_op(FS_MUL, 5'd0, 32'hAA, 32'hBB, 4'b0000);
        @(posedge clk); #1;
        present(6'h22, 5'd3, 32'h0, 32'h77, 4'b1111);
        wr_ready = 1'b0;
        @(posedge clk); #1;
        alu_valid = 1'b0;
        total++; if (wr_en !== 1'b1 || HI !== 32'hAA) begin bad++; $display("FAIL mrst_pre got=%b/%h exp=1/000000aa", wr_en, HI); end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        total++; if (wr_en !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mrst_wr_en got=%b/%b exp=0/0", wr_en, busy); end
        total++; if (HI !== '0 || LO !== '0 || {C_q, V_q, N_q, Z_q} !== 4'b0) begin bad++; $display("FAIL mrst_state got=%h/%h/%b exp=0/0/0000", HI, LO, {C_q, V_q, N_q, Z_q}); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        total++; if (alu_ready !== 1'b1 || wr_en !== 1'b0) begin bad++; $display("FAIL mrst_release got=%b/%b exp=1/0", alu_ready, wr_en); end
    endtask

    task automatic test_random();
        logic [5:0]    fs;
        logic [4:0]    d;
        logic [DW-1:0] yh, yl;
        logic [3:0]    cvnz;
        logic [DW+4:0] exp;
        int            sel, stall;
        for (int n = 0; n < 80; n++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0: fs = FS_MUL;
                1: fs = FS_DIV;
                2: fs = FS_MFHI;
                3: fs = FS_MFLO;
                default: begin
                    fs = 6'($urandom_range(0, 63));
                    while (fs == FS_MUL || fs == FS_DIV || fs == FS_MFHI || fs == FS_MFLO)
                        fs = 6'($urandom_range(0, 63));
                end
            endcase
            d = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            yh = $urandom;
            yl = $urandom;
            cvnz = 4'($urandom_range(0, 15));
            present(fs, d, yh, yl, cvnz);
            wr_ready = 1'($urandom_range(0, 1));
            model_op(fs, d, yh, yl, cvnz);
            @(posedge clk); #1;
            alu_valid = 1'b0;
            wr_ready = 1'b0;
            total++; if (HI !== m_hi || LO !== m_lo || {C_q, V_q, N_q, Z_q} !== m_flags) begin bad++; $display("FAIL rnd_arch[%0d] got=%h/%h/%b exp=%h/%h/%b", n, HI, LO, {C_q, V_q, N_q, Z_q}, m_hi, m_lo, m_flags); end
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                stall = $urandom_range(0, 3);
                for (int s = 0; s <= stall; s++) begin
                    total++; if (wr_en !== 1'b1 || alu_ready !== 1'b0 || {wr_addr, wr_data} !== exp) begin bad++; $display("FAIL rnd_write[%0d] got=%b/%b/%h exp=1/0/%h", n, wr_en, alu_ready, {wr_addr, wr_data}, exp); end
                    if (s < stall) begin @(posedge clk); #1; end
                end
                wr_ready = 1'b1;
                @(posedge clk); #1;
                wr_ready = 1'b0;
                total++; if (wr_en !== 1'b0 || alu_ready !== 1'b1) begin bad++; $display("FAIL rnd_retire[%0d] got=%b/%b exp=0/1", n, wr_en, alu_ready); end
            end else begin
                total++; if (wr_en !== 1'b0 || alu_ready !== 1'b1) begin bad++; $display("FAIL rnd_nowrite[%0d] got=%b/%b exp=0/1", n, wr_en, alu_ready); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_add_stall();
        test_back_to_back();
        test_zero_target();
        test_busy_drop();
        test_mid_write_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
